i2c_config_sequencer: RTL and testbench

I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

---
 rtl/i2c_cfg_pkg.sv | 49 ++++
 rtl/i2c_cfg_rom.sv | 15 +
 rtl/i2c_config_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared types and the default codec register table
// for the I2C configuration sequencer.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] W_LIN_L  = 16'h0097;
  localparam logic [15:0] W_LIN_R  = 16'h0297;
  localparam logic [15:0] W_HP_L   = 16'h0479;
  localparam logic [15:0] W_HP_R   = 16'h0679;
  localparam logic [15:0] W_APATH  = 16'h0815;
  localparam logic [15:0] W_DPATH  = 16'h0A00;
  localparam logic [15:0] W_POWER  = 16'h0C00;
  localparam logic [15:0] W_FORMAT = 16'h0E42;
  localparam logic [15:0] W_SRATE  = 16'h1019;
  localparam logic [15:0] W_ACTIVE = 16'h1201;

  localparam int DEF_WORDS = 10;

  function automatic logic [15:0] def_word(
    input logic [5:0] idx
  );
    logic [15:0] w;
    case (idx)
      6'd0:    w = W_LIN_L;
      6'd1:    w = W_LIN_R;
      6'd2:    w = W_HP_L;
      6'd3:    w = W_HP_R;
      6'd4:    w = W_APATH;
      6'd5:    w = W_DPATH;
      6'd6:    w = W_POWER;
      6'd7:    w = W_FORMAT;
      6'd8:    w = W_SRATE;
      6'd9:    w = W_ACTIVE;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Word-index to configuration-word lookup.
// Indices past the default table read as zero.
module i2c_cfg_rom
  import i2c_cfg_pkg::*;
(
  input  logic [5:0]  i_idx,
  output logic [15:0] o_word
);

  // pure table lookup
  always_comb begin
    o_word = def_word(i_idx);
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Bit-banged I2C write sequencer that streams a table
// of 16-bit register words to one slave, with retries.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int         N_WORDS   = 10,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         QDIV      = 4,
  parameter int         MAX_RETRY = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_sdat,
  output logic       o_sclk,
  output logic       o_sdat,
  output logic       o_oen,
  output logic       o_busy,
  output logic       o_finished,
  output logic       o_error,
  output logic [5:0] o_word_idx
);

  localparam int QW = $clog2(QDIV) + 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);
  localparam logic [3:0] RMAX = 4'(MAX_RETRY);
  localparam logic [5:0] LAST = 6'(N_WORDS - 1);
  localparam logic [7:0] ADDR_B = {DEV_ADDR, 1'b0};

  state_t        r_state;
  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_quar;
  logic [2:0]    r_bit;
  logic [1:0]    r_byte;
  logic [3:0]    r_retry;
  logic          r_nack;
  logic [5:0]    r_idx;
  logic          r_sclk;
  logic          r_sdat;
  logic          r_oen;
  logic          r_busy;
  logic          r_fin;
  logic          r_err;

  state_t        w_nstate;
  logic [QW-1:0] w_nqcnt;
  logic [1:0]    w_nquar;
  logic [2:0]    w_nbit;
  logic [1:0]    w_nbyte;
  logic [3:0]    w_nretry;
  logic          w_nnack;
  logic [5:0]    w_nidx;
  logic          w_tick;
  logic          w_seg_end;
  logic          w_accept;
  logic [15:0]   w_word;
  logic [7:0]    w_byte;
  logic          w_scl;
  logic          w_sda;
  logic          w_oen;

  assign w_tick    = (r_qcnt == QLAST);
  assign w_seg_end = w_tick && (r_quar == 2'd3);
  assign w_accept  = (r_state == S_IDLE) && i_start;

  i2c_cfg_rom u_rom (
    .i_idx  (w_nidx),
    .o_word (w_word)
  );

  // next bus position: state, quarter, bit and byte
  always_comb begin
    w_nstate = r_state;
    w_nqcnt  = w_tick ? '0 : r_qcnt + 1'b1;
    w_nquar  = w_tick ? r_quar + 2'd1 : r_quar;
    w_nbit   = r_bit;
    w_nbyte  = r_byte;
    w_nretry = r_retry;
    w_nnack  = r_nack;
    w_nidx   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        w_nqcnt = '0;
        w_nquar = 2'd0;
        if (i_start) begin
          w_nstate = S_START;
          w_nidx   = 6'd0;
          w_nretry = 4'd0;
          w_nnack  = 1'b0;
        end
      end
      S_START: begin
        if (w_seg_end) begin
          w_nstate = S_BIT;
          w_nbit   = 3'd7;
          w_nbyte  = 2'd0;
        end
      end
      S_BIT: begin
        if (w_seg_end) begin
          if (r_bit == 3'd0) w_nstate = S_ACK;
          else w_nbit = r_bit - 3'd1;
        end
      end
      S_ACK: begin
        if (w_tick && r_quar == 2'd2)
          w_nnack = i_sdat;
        if (w_seg_end) begin
          if (r_nack || r_byte == 2'd2) begin
            w_nstate = S_STOP;
          end else begin
            w_nstate = S_BIT;
            w_nbit   = 3'd7;
            w_nbyte  = r_byte + 2'd1;
          end
        end
      end
      S_STOP: begin
        if (w_seg_end) begin
          if (!r_nack) begin
            w_nstate = S_GAP;
          end else if (r_retry < RMAX) begin
            w_nstate = S_START;
            w_nretry = r_retry + 4'd1;
            w_nnack  = 1'b0;
          end else begin
            w_nstate = S_ERR;
          end
        end
      end
      S_GAP: begin
        if (w_seg_end) begin
          if (r_idx == LAST) begin
            w_nstate = S_DONE;
          end else begin
            w_nstate = S_START;
            w_nidx   = r_idx + 6'd1;
            w_nretry = 4'd0;
            w_nnack  = 1'b0;
          end
        end
      end
      S_DONE, S_ERR: begin
        w_nstate = S_IDLE;
        w_nqcnt  = '0;
        w_nquar  = 2'd0;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // bus levels for the next position
  always_comb begin
    unique case (w_nbyte)
      2'd0:    w_byte = ADDR_B;
      2'd1:    w_byte = w_word[15:8];
      default: w_byte = w_word[7:0];
    endcase
    w_scl = 1'b1;
    w_sda = 1'b1;
    w_oen = 1'b1;
    unique case (w_nstate)
      S_START: begin
        w_scl = (w_nquar != 2'd3);
        w_sda = (w_nquar < 2'd2);
      end
      S_BIT: begin
        w_scl = (w_nquar == 2'd1) || (w_nquar == 2'd2);
        w_sda = w_byte[w_nbit];
      end
      S_ACK: begin
        w_scl = (w_nquar == 2'd1) || (w_nquar == 2'd2);
        w_oen = 1'b0;
      end
      S_STOP: begin
        w_scl = (w_nquar != 2'd0);
        w_sda = (w_nquar >= 2'd2);
      end
      default: begin
        w_scl = 1'b1;
        w_sda = 1'b1;
        w_oen = 1'b1;
      end
    endcase
  end

  // sequencer state and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_qcnt  <= '0;
      r_quar  <= 2'd0;
      r_bit   <= 3'd7;
      r_byte  <= 2'd0;
      r_retry <= 4'd0;
      r_nack  <= 1'b0;
      r_idx   <= 6'd0;
      r_sclk  <= 1'b1;
      r_sdat  <= 1'b1;
      r_oen   <= 1'b1;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_qcnt  <= w_nqcnt;
      r_quar  <= w_nquar;
      r_bit   <= w_nbit;
      r_byte  <= w_nbyte;
      r_retry <= w_nretry;
      r_nack  <= w_nnack;
      r_idx   <= w_nidx;
      r_sclk  <= w_scl;
      r_sdat  <= w_sda;
      r_oen   <= w_oen;
      r_busy  <= (w_nstate != S_IDLE) &&
                 (w_nstate != S_DONE) &&
                 (w_nstate != S_ERR);
      r_fin   <= (w_nstate == S_DONE);
      if (w_accept)
        r_err <= 1'b0;
      else if (w_nstate == S_ERR)
        r_err <= 1'b1;
    end
  end

  assign o_sclk     = r_sclk;
  assign o_sdat     = r_sdat;
  assign o_oen      = r_oen;
  assign o_busy     = r_busy;
  assign o_finished = r_fin;
  assign o_error    = r_err;
  assign o_word_idx = r_idx;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Randomized bench: bus-level slave/decoder plus a
// transaction-level model of words, retries and timing.
module tb_i2c_config_sequencer;

  localparam int NW   = 10;
  localparam int Q    = 2;
  localparam int MAXR = 2;
  localparam int SEG  = 4 * Q;

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_sdat;
  logic       o_sclk;
  logic       o_sdat;
  logic       o_oen;
  logic       o_busy;
  logic       o_finished;
  logic       o_error;
  logic [5:0] o_word_idx;

  i2c_config_sequencer #(
    .N_WORDS   (NW),
    .DEV_ADDR  (7'h1A),
    .QDIV      (Q),
    .MAX_RETRY (MAXR)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_sdat     (i_sdat),
    .o_sclk     (o_sclk),
    .o_sdat     (o_sdat),
    .o_oen      (o_oen),
    .o_busy     (o_busy),
    .o_finished (o_finished),
    .o_error    (o_error),
    .o_word_idx (o_word_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] tbl [NW] = '{
    16'h0097, 16'h0297, 16'h0479, 16'h0679,
    16'h0815, 16'h0A00, 16'h0C00, 16'h0E42,
    16'h1019, 16'h1201
  };

  // plan[t]: byte index the slave NACKs in txn t, 3 = all ACK
  int          plan [64];
  int          plan_base;
  logic [31:0] txq [$];
  logic [31:0] exp_q [$];
  int          viol;
  bit          m_in_txn;
  int          m_nbits;
  int          m_nbytes;

  int n_chk;
  int n_pass;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // bus monitor and ACK/NACK slave
  initial begin
    logic       p_scl;
    logic       p_sda;
    logic       line;
    logic [7:0] sh;
    logic [7:0] cb [3];
    int         m_t;
    int         k;
    i_sdat = 1'b1;
    p_scl = 1'b1;
    p_sda = 1'b1;
    m_in_txn = 0;
    m_nbits = 0;
    m_nbytes = 0;
    viol = 0;
    m_t = 0;
    sh = 8'h00;
    cb = '{default: 8'h00};
    forever begin
      @(negedge clk);
      line = o_oen ? o_sdat : i_sdat;
      if (!i_rst_n) begin
        m_in_txn = 0;
        m_nbits = 0;
        m_nbytes = 0;
        i_sdat = 1'b1;
      end else begin
        if (!o_oen && !(m_in_txn && m_nbits >= 8))
          viol++;
        if (p_scl && o_sclk && line != p_sda) begin
          if (!line) begin
            if (m_in_txn) viol++;
            m_in_txn = 1;
            m_nbits = 0;
            m_nbytes = 0;
            cb = '{default: 8'h00};
            m_t = txq.size() - plan_base;
          end else begin
            if (!m_in_txn || m_nbits != 1) viol++;
            if (m_in_txn)
              txq.push_back({8'(m_nbytes), cb[0],
                             cb[1], cb[2]});
            m_in_txn = 0;
          end
        end else if (!p_scl && o_sclk && m_in_txn) begin
          if (m_nbits == 9) m_nbits = 0;
          if (m_nbits < 8) begin
            sh = {sh[6:0], line};
            m_nbits++;
          end else begin
            if (m_nbytes < 3) cb[m_nbytes] = sh;
            m_nbytes++;
            m_nbits = 9;
          end
        end else if (p_scl && !o_sclk && m_in_txn) begin
          if (m_nbits == 8) begin
            k = (m_t >= 0 && m_t < 64) ? plan[m_t] : 3;
            i_sdat = (k == m_nbytes);
          end else if (m_nbits == 9) begin
            i_sdat = 1'b1;
          end
        end
      end
      p_scl = o_sclk;
      p_sda = line;
    end
  end

  // transaction-level expectation from the plan
  task automatic model(output int ncyc, output bit eerr,
                       output int eidx);
    int w;
    int a;
    int t;
    int k;
    int sent;
    logic [15:0] wd;
    w = 0;
    a = 0;
    t = 0;
    ncyc = 0;
    eerr = 0;
    exp_q.delete();
    while (w < NW) begin
      k = (t < 64) ? plan[t] : 3;
      sent = (k > 2) ? 3 : k + 1;
      wd = tbl[w];
      exp_q.push_back({8'(sent), 8'h34,
                       (sent >= 2) ? wd[15:8] : 8'h00,
                       (sent == 3) ? wd[7:0] : 8'h00});
      ncyc += (2 + 9 * sent) * SEG;
      t++;
      if (k > 2) begin
        ncyc += SEG;
        w++;
        a = 0;
      end else begin
        a++;
        if (a > MAXR) begin
          eerr = 1;
          break;
        end
      end
    end
    eidx = eerr ? w : NW - 1;
  endtask

  task automatic run_seq(input int poke, output int cyc,
                         output int nfin, output bit err);
    bit poked;
    plan_base = txq.size();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk("busy_on", 32'(o_busy), 1);
    chk("err_clr", 32'(o_error), 0);
    cyc = 0;
    nfin = 0;
    err = 0;
    poked = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      i_start = 1'b0;
      if (poke >= 0 && !poked && m_in_txn &&
          txq.size() - plan_base == poke) begin
        i_start = 1'b1;
        poked = 1;
      end
      if (o_finished) begin
        nfin = 1;
        chk("busy_fin", 32'(o_busy), 0);
        break;
      end
      if (o_error) begin
        err = 1;
        chk("busy_err", 32'(o_busy), 0);
        break;
      end
      if (cyc > 30000) begin
        chk("timeout", 1, 0);
        break;
      end
    end
    i_start = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (o_finished) nfin++;
    end
  endtask

  task automatic do_test(input string nm, input int poke);
    int ecyc;
    bit eerr;
    int eidx;
    int cyc;
    int nfin;
    bit err;
    int v0;
    int n;
    v0 = viol;
    model(ecyc, eerr, eidx);
    run_seq(poke, cyc, nfin, err);
    chk({nm, "_cyc"}, cyc, ecyc);
    chk({nm, "_fin"}, nfin, eerr ? 0 : 1);
    chk({nm, "_err"}, 32'(err), 32'(eerr));
    chk({nm, "_busy"}, 32'(o_busy), 0);
    chk({nm, "_idx"}, 32'(o_word_idx), eidx);
    chk({nm, "_bus"}, {o_sclk, o_sdat, o_oen}, 3'b111);
    n = txq.size() - plan_base;
    chk({nm, "_ntxn"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk({nm, "_txn"}, txq[plan_base + i], exp_q[i]);
    chk({nm, "_proto"}, viol - v0, 0);
  endtask

  initial begin
    int guard;
    n_chk = 0;
    n_pass = 0;
    plan_base = 0;
    for (int i = 0; i < 64; i++) plan[i] = 3;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", 32'(o_sclk), 1);
    chk("rst_sda", 32'(o_sdat), 1);
    chk("rst_oen", 32'(o_oen), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_fin", 32'(o_finished), 0);
    chk("rst_err", 32'(o_error), 0);
    chk("rst_idx", 32'(o_word_idx), 0);
    i_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_test("allack", -1);
    chk("first_txn", txq[plan_base], 32'h03340097);

    plan[3] = 2;
    do_test("nack3", -1);
    plan[3] = 3;

    for (int i = 0; i < 64; i++) plan[i] = 0;
    do_test("nackall", -1);
    repeat (20) @(posedge clk);
    #1;
    chk("err_sticky", 32'(o_error), 1);
    chk("err_busy", 32'(o_busy), 0);
    chk("err_bus", {o_sclk, o_sdat, o_oen}, 3'b111);

    for (int i = 0; i < 64; i++) plan[i] = 3;
    do_test("poke5", 5);

    plan_base = txq.size();
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    guard = 0;
    while (!(m_in_txn && txq.size() - plan_base == 4 &&
             m_nbytes == 1 && m_nbits == 4) &&
           guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("rst_reach", 32'(guard < 20000), 1);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_bus", {o_sclk, o_sdat, o_oen}, 3'b111);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_idx", 32'(o_word_idx), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_nostop", txq.size() - plan_base, 4);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_test("afterrst", -1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++)
        plan[i] = ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(0, 2)) : 3;
      do_test("rand", -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
